// File: rtl/sat_accumulator_if.sv
// rtl/sat_accumulator_if.sv - sample-in / result-out bundle for sat_accumulator
interface sat_acc_if #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int CW = $clog2(CHANNELS);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_data;
  logic [CW-1:0]        in_ch;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_data;
  logic [CW-1:0]        out_ch;
  logic                 out_sat;
  logic [CNT_WIDTH-1:0] sat_cnt;

  modport master (
    output in_valid, in_data, in_ch, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_ch, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_data, in_ch, in_last, out_ready,
    output in_ready, out_valid, out_data, out_ch, out_sat, sat_cnt
  );
endinterface

// File: rtl/sat_accumulator.sv
// rtl/sat_accumulator.sv - multi-channel saturating accumulator with framed output
// Accumulators are read straight from registers, so same-channel samples on consecutive cycles chain without a hazard.
module sat_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CHANNELS  = 4,
  parameter int SIGNED    = 0,
  parameter int CNT_WIDTH = 16
) (
  input  logic     sys_clk,
  input  logic     sys_rst_n,
  input  logic     clr,
  sat_acc_if.slave bus
);
  localparam int CW = $clog2(CHANNELS);
  localparam int XW = ACC_WIDTH + 1 - WIDTH;
  localparam logic [ACC_WIDTH-1:0] UMAX = {ACC_WIDTH{1'b1}};
  localparam logic [ACC_WIDTH-1:0] SMAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic [ACC_WIDTH-1:0] acc_q [CHANNELS];
  logic [CHANNELS-1:0]  sat_flag_q;
  logic                 out_valid_q;
  logic [ACC_WIDTH-1:0] out_data_q;
  logic [CW-1:0]        out_ch_q;
  logic                 out_sat_q;
  logic [CNT_WIDTH-1:0] sat_cnt_q;

  logic [CW-1:0]        ch;
  logic [ACC_WIDTH-1:0] acc_cur;
  logic [ACC_WIDTH-1:0] acc_d;
  logic [ACC_WIDTH:0]   add_a;
  logic [ACC_WIDTH:0]   add_b;
  logic [ACC_WIDTH:0]   sum;
  logic                 clamp;
  logic                 in_ready;
  logic                 accept;

  assign in_ready = !clr && (!out_valid_q || bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // One extra bit of headroom makes overflow visible in the top two sum bits.
  always_comb begin
    ch      = bus.in_ch;
    acc_cur = acc_q[ch];
    if (SIGNED != 0) begin
      add_a = {acc_cur[ACC_WIDTH-1], acc_cur};
      add_b = {{XW{bus.in_data[WIDTH-1]}}, bus.in_data};
    end else begin
      add_a = {1'b0, acc_cur};
      add_b = {{XW{1'b0}}, bus.in_data};
    end
    sum   = add_a + add_b;
    acc_d = sum[ACC_WIDTH-1:0];
    clamp = 1'b0;
    if (SIGNED != 0) begin
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        clamp = 1'b1;
        acc_d = sum[ACC_WIDTH] ? SMIN : SMAX;
      end
    end else if (sum[ACC_WIDTH]) begin
      clamp = 1'b1;
      acc_d = UMAX;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      sat_flag_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_sat_q   <= 1'b0;
      sat_cnt_q   <= '0;
    end else if (clr) begin
      for (int i = 0; i < CHANNELS; i++) acc_q[i] <= '0;
      sat_flag_q  <= '0;
      out_valid_q <= 1'b0;
      sat_cnt_q   <= '0;
    end else begin
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        if (bus.in_last) begin
          out_data_q     <= acc_d;
          out_ch_q       <= ch;
          out_sat_q      <= sat_flag_q[ch] | clamp;
          out_valid_q    <= 1'b1;
          acc_q[ch]      <= '0;
          sat_flag_q[ch] <= 1'b0;
        end else begin
          acc_q[ch] <= acc_d;
          if (clamp) sat_flag_q[ch] <= 1'b1;
        end
        if (clamp && (sat_cnt_q != {CNT_WIDTH{1'b1}})) sat_cnt_q <= sat_cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.sat_cnt   = sat_cnt_q;
endmodule

// File: tb/tb_sat_accumulator.sv
// tb/tb_sat_accumulator.sv - directed bench for sat_accumulator, unsigned and signed instances
module tb_sat_accumulator;
  logic clk = 1'b0;
  logic rst_n;
  logic clr;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sat_acc_if #(.WIDTH(4), .ACC_WIDTH(6), .CHANNELS(2), .CNT_WIDTH(2))  b0 ();
  sat_acc_if #(.WIDTH(4), .ACC_WIDTH(6), .CHANNELS(2), .CNT_WIDTH(16)) b1 ();

  sat_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .CHANNELS(2), .SIGNED(0), .CNT_WIDTH(2)) u0 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr), .bus(b0));
  sat_accumulator #(.WIDTH(4), .ACC_WIDTH(6), .CHANNELS(2), .SIGNED(1), .CNT_WIDTH(16)) u1 (
    .sys_clk(clk), .sys_rst_n(rst_n), .clr(clr), .bus(b1));

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Presents one sample for exactly one edge; caller guarantees in_ready.
  task automatic drive(input bit s, input logic [3:0] d, input logic ch, input logic last);
    if (!s) begin
      b0.in_valid = 1'b1; b0.in_data = d; b0.in_ch = ch; b0.in_last = last;
    end else begin
      b1.in_valid = 1'b1; b1.in_data = d; b1.in_ch = ch; b1.in_last = last;
    end
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    b1.in_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0d expected 0", b0.out_valid); end
    checks++; if (b0.out_data !== 6'd0) begin errors++; $display("FAIL rst_data: got %0d expected 0", b0.out_data); end
    checks++; if (b0.out_ch !== 1'b0 || b0.out_sat !== 1'b0) begin errors++; $display("FAIL rst_ch_sat: got %0d/%0d expected 0/0", b0.out_ch, b0.out_sat); end
    checks++; if (b0.sat_cnt !== 2'd0 || b1.sat_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", b0.sat_cnt, b1.sat_cnt); end
    rst_n = 1'b1;
    #1;
    checks++; if (b0.in_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %0d expected 1", b0.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_clamp();
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'd15, 1'b0, 1'b0);
      checks++; if (b0.sat_cnt !== 2'd0 || b0.out_valid !== 1'b0) begin errors++; $display("FAIL uns_partial%0d: got cnt %0d valid %0d expected 0/0", i, b0.sat_cnt, b0.out_valid); end
    end
    drive(0, 4'd15, 1'b0, 1'b1);
    checks++; if (b0.out_valid !== 1'b1) begin errors++; $display("FAIL uns_valid: got %0d expected 1", b0.out_valid); end
    checks++; if (b0.out_data !== 6'd63) begin errors++; $display("FAIL uns_data: got %0d expected 63", b0.out_data); end
    checks++; if (b0.out_ch !== 1'b0 || b0.out_sat !== 1'b1) begin errors++; $display("FAIL uns_ch_sat: got %0d/%0d expected 0/1", b0.out_ch, b0.out_sat); end
    checks++; if (b0.sat_cnt !== 2'd1) begin errors++; $display("FAIL uns_cnt: got %0d expected 1", b0.sat_cnt); end
    @(posedge clk); #1;
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL uns_drain: got %0d expected 0", b0.out_valid); end
  endtask

  task automatic test_interleave();
    do_clr();
    drive(0, 4'd3, 1'b0, 1'b0);
    drive(0, 4'd5, 1'b1, 1'b0);
    drive(0, 4'd4, 1'b0, 1'b1);
    checks++; if (b0.out_data !== 6'd7 || b0.out_ch !== 1'b0 || b0.out_sat !== 1'b0) begin errors++; $display("FAIL il_first: got %0d/%0d/%0d expected 7/0/0", b0.out_data, b0.out_ch, b0.out_sat); end
    drive(0, 4'd2, 1'b1, 1'b1);
    checks++; if (b0.out_data !== 6'd7 || b0.out_ch !== 1'b1 || b0.out_sat !== 1'b0 || b0.out_valid !== 1'b1) begin errors++; $display("FAIL il_second: got %0d/%0d/%0d expected 7/1/0", b0.out_data, b0.out_ch, b0.out_sat); end
    drive(0, 4'd1, 1'b0, 1'b1);
    checks++; if (b0.out_data !== 6'd1 || b0.out_ch !== 1'b0) begin errors++; $display("FAIL il_zero0: got %0d/%0d expected 1/0", b0.out_data, b0.out_ch); end
    drive(0, 4'd1, 1'b1, 1'b1);
    checks++; if (b0.out_data !== 6'd1 || b0.out_ch !== 1'b1) begin errors++; $display("FAIL il_zero1: got %0d/%0d expected 1/1", b0.out_data, b0.out_ch); end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    for (int i = 0; i < 5; i++) drive(1, 4'b1000, 1'b1, 1'b0);
    drive(1, 4'b1000, 1'b1, 1'b1);
    checks++; if (b1.out_data !== 6'b100000 || b1.out_ch !== 1'b1) begin errors++; $display("FAIL sg_neg: got %0d/%0d expected 32/1", b1.out_data, b1.out_ch); end
    checks++; if (b1.out_sat !== 1'b1 || b1.sat_cnt !== 16'd2) begin errors++; $display("FAIL sg_neg_sat: got %0d/%0d expected 1/2", b1.out_sat, b1.sat_cnt); end
    drive(1, 4'b1000, 1'b1, 1'b0);
    drive(1, 4'd7, 1'b1, 1'b1);
    checks++; if (b1.out_data !== 6'b111111 || b1.out_sat !== 1'b0) begin errors++; $display("FAIL sg_m1: got %0d/%0d expected 63/0", b1.out_data, b1.out_sat); end
    for (int i = 0; i < 4; i++) drive(1, 4'd7, 1'b0, 1'b0);
    drive(1, 4'd7, 1'b0, 1'b1);
    checks++; if (b1.out_data !== 6'd31 || b1.out_sat !== 1'b1 || b1.sat_cnt !== 16'd3) begin errors++; $display("FAIL sg_pos: got %0d/%0d/%0d expected 31/1/3", b1.out_data, b1.out_sat, b1.sat_cnt); end
    for (int i = 0; i < 5; i++) drive(1, 4'd7, 1'b0, 1'b0);
    drive(1, 4'b1000, 1'b0, 1'b1);
    checks++; if (b1.out_data !== 6'd23 || b1.out_sat !== 1'b1 || b1.sat_cnt !== 16'd4) begin errors++; $display("FAIL sg_pullback: got %0d/%0d/%0d expected 23/1/4", b1.out_data, b1.out_sat, b1.sat_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    do_clr();
    b0.out_ready = 1'b0;
    drive(0, 4'd5, 1'b0, 1'b1);
    b0.in_valid = 1'b1; b0.in_data = 4'd9; b0.in_ch = 1'b1; b0.in_last = 1'b1;
    #1;
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0d expected 0", b0.in_ready); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if (b0.out_valid !== 1'b1 || b0.out_data !== 6'd5 || b0.out_ch !== 1'b0 || b0.out_sat !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got %0d/%0d/%0d/%0d expected 1/5/0/0", i, b0.out_valid, b0.out_data, b0.out_ch, b0.out_sat);
      end
    end
    b0.out_ready = 1'b1;
    @(negedge clk);
    checks++; if (b0.out_valid !== 1'b1 || b0.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got %0d/%0d expected 1/1", b0.out_valid, b0.in_ready); end
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
    checks++; if (b0.out_valid !== 1'b1 || b0.out_data !== 6'd9 || b0.out_ch !== 1'b1) begin errors++; $display("FAIL bp_replace: got %0d/%0d/%0d expected 1/9/1", b0.out_valid, b0.out_data, b0.out_ch); end
    @(posedge clk); #1;
    checks++; if (b0.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: got %0d expected 0", b0.out_valid); end
  endtask

  task automatic test_cnt_sat();
    logic [1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3; exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    do_clr();
    for (int i = 0; i < 4; i++) drive(0, 4'd15, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(0, 4'd15, 1'b0, 1'b0);
      checks++; if (b0.sat_cnt !== exp_cnt[i]) begin errors++; $display("FAIL cnt_sat%0d: got %0d expected %0d", i, b0.sat_cnt, exp_cnt[i]); end
    end
    drive(0, 4'd0, 1'b0, 1'b1);
    checks++; if (b0.out_data !== 6'd63 || b0.out_sat !== 1'b1) begin errors++; $display("FAIL cnt_frame: got %0d/%0d expected 63/1", b0.out_data, b0.out_sat); end
    @(posedge clk); #1;
  endtask

  task automatic test_clr();
    do_clr();
    b0.out_ready = 1'b0;
    drive(0, 4'd2, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 4'd15, 1'b0, 1'b0);
    drive(0, 4'd15, 1'b0, 1'b1);
    checks++; if (b0.out_valid !== 1'b1 || b0.sat_cnt !== 2'd1) begin errors++; $display("FAIL clr_setup: got %0d/%0d expected 1/1", b0.out_valid, b0.sat_cnt); end
    b0.out_ready = 1'b1;
    clr = 1'b1;
    b0.in_valid = 1'b1; b0.in_data = 4'd3; b0.in_ch = 1'b1; b0.in_last = 1'b1;
    #1;
    checks++; if (b0.in_ready !== 1'b0) begin errors++; $display("FAIL clr_ready: got %0d expected 0", b0.in_ready); end
    @(posedge clk); #1;
    clr = 1'b0;
    b0.in_valid = 1'b0;
    checks++; if (b0.out_valid !== 1'b0 || b0.sat_cnt !== 2'd0) begin errors++; $display("FAIL clr_state: got %0d/%0d expected 0/0", b0.out_valid, b0.sat_cnt); end
    drive(0, 4'd4, 1'b1, 1'b1);
    checks++; if (b0.out_data !== 6'd4 || b0.out_ch !== 1'b1 || b0.out_sat !== 1'b0) begin errors++; $display("FAIL clr_fresh: got %0d/%0d/%0d expected 4/1/0", b0.out_data, b0.out_ch, b0.out_sat); end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    b0.out_ready = 1'b0;
    drive(0, 4'd5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 4'd15, 1'b0, 1'b0);
    drive(0, 4'd15, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (b0.out_valid !== 1'b0 || b0.out_data !== 6'd0) begin errors++; $display("FAIL arst_out: got %0d/%0d expected 0/0", b0.out_valid, b0.out_data); end
    checks++; if (b0.out_ch !== 1'b0 || b0.out_sat !== 1'b0 || b0.sat_cnt !== 2'd0) begin errors++; $display("FAIL arst_misc: got %0d/%0d/%0d expected 0/0/0", b0.out_ch, b0.out_sat, b0.sat_cnt); end
    #1;
    rst_n = 1'b1;
    b0.out_ready = 1'b1;
    @(posedge clk); #1;
    drive(0, 4'd1, 1'b1, 1'b1);
    checks++; if (b0.out_data !== 6'd1 || b0.out_ch !== 1'b1 || b0.out_sat !== 1'b0) begin errors++; $display("FAIL arst_fresh: got %0d/%0d/%0d expected 1/1/0", b0.out_data, b0.out_ch, b0.out_sat); end
  endtask

  initial begin
    rst_n = 1'b0;
    clr   = 1'b0;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.in_ch = '0; b0.in_last = 1'b0; b0.out_ready = 1'b1;
    b1.in_valid = 1'b0; b1.in_data = '0; b1.in_ch = '0; b1.in_last = 1'b0; b1.out_ready = 1'b1;
    test_reset();
    test_unsigned_clamp();
    test_interleave();
    test_signed();
    test_backpressure();
    test_cnt_sat();
    test_clr();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sat_accumulator.md
# sat_accumulator

Multi-channel saturating accumulator, the parametrised successor to the team's single-cycle unsigned saturating adder. It sums a stream of time-multiplexed samples per channel into ACC_WIDTH-bit registers. Every addition clamps to the representable range, in either unsigned or signed two's-complement mode. A completed frame is emitted through a registered valid/ready output with a per-frame saturation flag and a global saturation-event counter. It sits after the sample-path datapath, ahead of the framing/reporting logic.

## Interface
- WIDTH, 8: input sample width; must be at least 2.
- ACC_WIDTH, 16: accumulator and result width; must be at least WIDTH.
- CHANNELS, 4: number of independent accumulators; must be at least 2.
- SIGNED, 0: 0 selects unsigned mode (zero-extend, clamp high only); 1 selects two's-complement mode (sign-extend, clamp both ends).
- CNT_WIDTH, 16: saturation-event counter width.
- CW: local parameter, equal to $clog2(CHANNELS).

Ports:
- sys_clk  in  1  single clock; all logic is rising-edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear of all state.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  sample.
- in_ch  in  CW  target channel; values ≥ CHANNELS are illegal.
- in_last  in  1  this sample closes the channel's frame.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_data  out  ACC_WIDTH  frame sum.
- out_ch  out  CW  channel of the result.
- out_sat  out  1  at least one clamp occurred in this frame.
- sat_cnt  out  CNT_WIDTH  total clamp events since reset or clr; saturates at all-ones and does not wrap.

## Operation
- Accept condition: in_valid && in_ready.
- in_ready = !clr && (!out_valid || out_ready). It is combinational and applies to all samples, not only last samples.
- On accept, sum = ext(acc[in_ch]) + ext(in_data), computed at ACC_WIDTH+1 bits.
  - Unsigned mode: if sum > 2^ACC_WIDTH−1, result = 2^ACC_WIDTH−1.
  - Signed mode: clamp to +2^(ACC_WIDTH−1)−1 on positive overflow and to −2^(ACC_WIDTH−1) on negative overflow.
  - Clamping is applied per addition. In signed mode, later samples may pull a clamped value back into range.
- On a clamp: set sat_flag[in_ch]. Increment sat_cnt by 1 unless it is already all-ones.
- Accept without in_last: acc[in_ch] ← result.
- Accept with in_last:
  - Load out_data ← result, out_ch ← in_ch, out_sat ← sat_flag[in_ch] OR (this addition clamped).
  - Set out_valid ← 1.
  - Reset acc[in_ch] ← 0 and sat_flag[in_ch] ← 0.
  - A one-sample frame is legal.
- Output handshake:
  - out_valid drops on out_valid && out_ready unless a new last sample is accepted in the same cycle. In that case the new result replaces the old one and out_valid stays 1.
  - out_data, out_ch and out_sat are held stable while out_valid && !out_ready.
- Other channels are never disturbed by an accept.
- Back-to-back samples to the same channel on consecutive cycles must accumulate correctly, with no stall and no read-after-write hazard.
- clr, at the next edge: all acc ← 0, all sat_flag ← 0, sat_cnt ← 0, out_valid ← 0. in_ready is 0 during clr, so no sample is taken. A pending output is discarded.

## Timing
- Reset values (async, while sys_rst_n = 0): out_valid 0, out_data 0, out_ch 0, out_sat 0, sat_cnt 0. All acc and sat_flag are 0. in_ready is 1 once sys_rst_n is high (and clr = 0).
- Latency: out_valid asserts on the edge that accepts the in_last sample. out_data is visible in the following cycle.
- Throughput: one sample per cycle while the output is empty or being drained.
- sat_cnt and out_sat are registered and update on the accepting edge.
- Reset asserted mid-frame or with a pending output: all state clears immediately and the partial frame is lost.
- Reset release is synchronised externally. The block does not require stimulus in the first cycle after release.

## Test plan
1. Unsigned clamp (WIDTH=4, ACC_WIDTH=6, CHANNELS=2). Send ch0 samples 15, 15, 15, 15, 15 (last) -> out_data=63, out_ch=0, out_sat=1, sat_cnt=1. The partial sums 15/30/45/60 must not clamp.
2. Interleaved channels. Send ch0 3, ch1 5, ch0 4 (last), ch1 2 (last) -> first result 7/ch0/sat 0, then 7/ch1/sat 0. Both accumulators read 0 afterward: a following one-sample frame of 1 returns 1.
3. Signed mode (SIGNED=1, same widths). Send ch1 −8 six times, the last flagged -> out_data=6'b100000 (−32), out_sat=1, sat_cnt=2. Then a ch1 frame of −8, +7 (last) returns −1 with out_sat=0.
4. Backpressure. Hold out_ready=0 with a result pending -> in_ready=0, and out_data/out_ch/out_sat stay stable for 10 cycles. Raise out_ready together with a new last sample -> the new result replaces the old with out_valid continuously 1.
5. Counter saturation (CNT_WIDTH=2). Generate 5 clamps -> sat_cnt reads 1, 2, 3, 3, 3.
6. Clear and reset mid-operation:
   - Assert clr mid-frame with a pending output -> out_valid=0, sat_cnt=0, the sample presented that cycle is not taken, and the next frame starts from 0.
   - Assert sys_rst_n=0 asynchronously between edges -> all outputs go to reset values immediately.
